// File: rtl/systolic_ctrl_pkg.sv
// Shared types and derived constants for the systolic-array sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package systolic_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FEED  = 3'd1,
    WRITE = 3'd2,
    CLEAR = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int DEF_SYSTOLIC_SIZE = 16;
  localparam int DEF_BUFFER_SIZE   = 27;

  // Fetch window plus the skew needed for the last word to cross the array.
  function automatic int calc_feed_cycles(input int buf_size, input int sys_size);
    return buf_size + 2 * sys_size - 1;
  endfunction

  localparam int FEED_CYCLES = calc_feed_cycles(DEF_BUFFER_SIZE, DEF_SYSTOLIC_SIZE);
  localparam int TILE_CYCLES = FEED_CYCLES + 1 + DEF_SYSTOLIC_SIZE + 1;
  localparam int PHASE_W     = $clog2(FEED_CYCLES + 1);

endpackage

// File: rtl/tile_addr_gen.sv
// Running base+offset pointers for IFM, WGT and OFM memories.
// Latency: addresses update on the clock edge after a control input is seen.
// Backpressure: none; the FSM decides when pointers move.
module tile_addr_gen
  import systolic_ctrl_pkg::*;
#(
  parameter int IFM_AW      = 19,
  parameter int WGT_AW      = 9,
  parameter int OFM_AW      = 22,
  parameter int BUFFER_SIZE = DEF_BUFFER_SIZE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              feed_step,
  input  logic              write_step,
  input  logic              advance,
  input  logic [IFM_AW-1:0] ifm_base,
  input  logic [WGT_AW-1:0] wgt_base,
  input  logic [OFM_AW-1:0] ofm_base,
  output logic [IFM_AW-1:0] ifm_addr,
  output logic [WGT_AW-1:0] wgt_addr,
  output logic [OFM_AW-1:0] ofm_addr
);

  localparam logic [IFM_AW-1:0] IFM_STRIDE = IFM_AW'(BUFFER_SIZE);

  logic [IFM_AW-1:0] ifm_tile;
  logic [WGT_AW-1:0] wgt_base_q;

  // IFM tile pointer accumulates one stride per tile (no multiplier); weights
  // restart from the same base every tile; OFM simply runs on across tiles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ifm_tile   <= '0;
      wgt_base_q <= '0;
      ifm_addr   <= '0;
      wgt_addr   <= '0;
      ofm_addr   <= '0;
    end else if (load) begin
      ifm_tile   <= ifm_base;
      wgt_base_q <= wgt_base;
      ifm_addr   <= ifm_base;
      wgt_addr   <= wgt_base;
      ofm_addr   <= ofm_base;
    end else begin
      if (advance) begin
        ifm_tile <= ifm_tile + IFM_STRIDE;
        ifm_addr <= ifm_tile + IFM_STRIDE;
        wgt_addr <= wgt_base_q;
      end else if (feed_step) begin
        ifm_addr <= ifm_addr + IFM_AW'(1);
        wgt_addr <= wgt_addr + WGT_AW'(1);
      end
      if (write_step) begin
        ofm_addr <= ofm_addr + OFM_AW'(1);
      end
    end
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Tile sequencer for the systolic array: fetch, propagate, drain, clear per tile.
// Latency: first fetch address one cycle after start; done 1+76*num_tiles cycles after start (defaults).
// Backpressure: none; start is ignored while busy, inputs are sampled only on an accepted start.
module systolic_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int SYSTOLIC_SIZE = DEF_SYSTOLIC_SIZE,
  parameter int BUFFER_SIZE   = DEF_BUFFER_SIZE,
  parameter int IFM_AW        = 19,
  parameter int WGT_AW        = 9,
  parameter int OFM_AW        = 22,
  parameter int TILE_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [TILE_W-1:0] num_tiles,
  input  logic [IFM_AW-1:0] ifm_base,
  input  logic [WGT_AW-1:0] wgt_base,
  input  logic [OFM_AW-1:0] ofm_base,
  output logic              busy,
  output logic              done,
  output logic              ifm_we_a,
  output logic              wgt_we_a,
  output logic [IFM_AW-1:0] ifm_addr_a,
  output logic [WGT_AW-1:0] wgt_addr_a,
  output logic              read_en,
  output logic              reset_pe,
  output logic              write_out_en,
  output logic              ofm_we_b,
  output logic [OFM_AW-1:0] ofm_addr_b
);

  localparam int FEED_N = calc_feed_cycles(BUFFER_SIZE, SYSTOLIC_SIZE);
  localparam int CW     = $clog2(FEED_N + 1);

  localparam logic [CW-1:0] FEED_LAST  = CW'(FEED_N);
  localparam logic [CW-1:0] FETCH_LAST = CW'(BUFFER_SIZE - 1);
  localparam logic [CW-1:0] WRITE_LAST = CW'(SYSTOLIC_SIZE - 1);

  state_t            state;
  logic [CW-1:0]     phase;
  logic [TILE_W-1:0] tile_idx;
  logic [TILE_W-1:0] num_q;

  logic load, feed_step, write_step, advance, last_tile;

  assign ifm_we_a = 1'b0;
  assign wgt_we_a = 1'b0;

  assign last_tile  = (tile_idx == num_q - TILE_W'(1));
  assign load       = (state == IDLE) && start && (num_tiles != '0);
  assign feed_step  = (state == FEED) && (phase < FETCH_LAST);
  assign write_step = (state == WRITE);
  assign advance    = (state == CLEAR) && !last_tile;

  tile_addr_gen #(
    .IFM_AW      (IFM_AW),
    .WGT_AW      (WGT_AW),
    .OFM_AW      (OFM_AW),
    .BUFFER_SIZE (BUFFER_SIZE)
  ) u_addr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .feed_step  (feed_step),
    .write_step (write_step),
    .advance    (advance),
    .ifm_base   (ifm_base),
    .wgt_base   (wgt_base),
    .ofm_base   (ofm_base),
    .ifm_addr   (ifm_addr_a),
    .wgt_addr   (wgt_addr_a),
    .ofm_addr   (ofm_addr_b)
  );

  // Sequencer FSM; every control output is set for the cycle being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      phase        <= '0;
      tile_idx     <= '0;
      num_q        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      read_en      <= 1'b0;
      write_out_en <= 1'b0;
      ofm_we_b     <= 1'b0;
      reset_pe     <= 1'b1;
    end else begin
      done     <= 1'b0;
      reset_pe <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (num_tiles == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= FEED;
              num_q    <= num_tiles;
              tile_idx <= '0;
              phase    <= '0;
            end
          end
        end
        FEED: begin
          // Cycle 0 only issues the first read; data appears one cycle later.
          if (phase == FEED_LAST) begin
            state        <= WRITE;
            phase        <= '0;
            read_en      <= 1'b0;
            write_out_en <= 1'b1;
            ofm_we_b     <= 1'b1;
          end else begin
            phase   <= phase + CW'(1);
            read_en <= 1'b1;
          end
        end
        WRITE: begin
          if (phase == WRITE_LAST) begin
            state        <= CLEAR;
            phase        <= '0;
            write_out_en <= 1'b0;
            ofm_we_b     <= 1'b0;
            reset_pe     <= 1'b1;
          end else begin
            phase <= phase + CW'(1);
          end
        end
        CLEAR: begin
          tile_idx <= tile_idx + TILE_W'(1);
          if (last_tile) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= FEED;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Scoreboard bench for systolic_ctrl: stimulus pushes expected events, a monitor pops and compares.
// Latency: expectations are keyed to absolute cycle numbers of the start pulse.
// Backpressure: n/a.
module tb_systolic_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_tiles = '0;
  logic [18:0] ifm_base = '0;
  logic [8:0]  wgt_base = '0;
  logic [21:0] ofm_base = '0;
  logic        busy, done, ifm_we_a, wgt_we_a, read_en, reset_pe, write_out_en, ofm_we_b;
  logic [18:0] ifm_addr_a;
  logic [8:0]  wgt_addr_a;
  logic [21:0] ofm_addr_b;

  systolic_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_tiles    (num_tiles),
    .ifm_base     (ifm_base),
    .wgt_base     (wgt_base),
    .ofm_base     (ofm_base),
    .busy         (busy),
    .done         (done),
    .ifm_we_a     (ifm_we_a),
    .wgt_we_a     (wgt_we_a),
    .ifm_addr_a   (ifm_addr_a),
    .wgt_addr_a   (wgt_addr_a),
    .read_en      (read_en),
    .reset_pe     (reset_pe),
    .write_out_en (write_out_en),
    .ofm_we_b     (ofm_we_b),
    .ofm_addr_b   (ofm_addr_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [18:0] ifm;
    logic [8:0]  wgt;
  } feed_t;

  feed_t       exp_feed[$];
  int          exp_run[$];
  logic [21:0] exp_ofm[$];
  int          exp_pe[$];
  int          exp_done[$];

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic miss(input string name);
    checks++;
    $display("FAIL %s: output seen with no expectation queued (cycle %0d)", name, cyc);
  endtask

  // Monitor: sampled on the falling edge, well away from the active edge.
  logic        prev_re = 1'b0;
  logic        prev_rst = 1'b0;
  logic [18:0] prev_ifm = '0;
  logic [8:0]  prev_wgt = '0;
  int          k = 0;
  int          runlen = 0;

  always @(negedge clk) begin
    feed_t       f;
    logic [21:0] o;
    int          e;
    if (!rst_n) begin
      k      = 0;
      runlen = 0;
    end else if (prev_rst) begin
      if (read_en && !prev_re) begin
        k      = 0;
        runlen = 0;
      end
      if (read_en) begin
        runlen++;
        k++;
        // The k-th read cycle follows the cycle that presented fetch index k-1.
        if (k <= 27) begin
          if (exp_feed.size() == 0) miss("feed_addr");
          else begin
            f = exp_feed.pop_front();
            chk("ifm_addr", prev_ifm, f.ifm);
            chk("wgt_addr", prev_wgt, f.wgt);
          end
        end
      end
      if (!read_en && prev_re) begin
        if (exp_run.size() == 0) miss("read_en_run");
        else begin
          e = exp_run.pop_front();
          chk("read_en_len", runlen, e);
        end
      end
      if (ofm_we_b) begin
        if (exp_ofm.size() == 0) miss("ofm_write");
        else begin
          o = exp_ofm.pop_front();
          chk("ofm_addr", ofm_addr_b, o);
          chk("write_out_en", write_out_en, 1);
        end
      end
      if (reset_pe) begin
        if (exp_pe.size() == 0) miss("reset_pe");
        else begin
          e = exp_pe.pop_front();
          chk("reset_pe_cycle", cyc, e);
        end
      end
      if (done) begin
        if (exp_done.size() == 0) miss("done");
        else begin
          e = exp_done.pop_front();
          chk("done_cycle", cyc, e);
          chk("busy_at_done", busy, 1);
        end
      end
      if (read_en || write_out_en || reset_pe)
        chk("ctrl_onehot", int'(read_en) + int'(write_out_en) + int'(reset_pe), 1);
    end
    prev_rst = rst_n;
    prev_re  = read_en;
    prev_ifm = ifm_addr_a;
    prev_wgt = wgt_addr_a;
  end

  task automatic push_job(input int s, input int n, input int ib, input int wb, input int ob);
    feed_t f;
    for (int t = 0; t < n; t++) begin
      for (int c = 0; c < 27; c++) begin
        f.ifm = 19'(ib + 27 * t + c);
        f.wgt = 9'(wb + c);
        exp_feed.push_back(f);
      end
      exp_run.push_back(58);
      for (int r = 0; r < 16; r++) exp_ofm.push_back(22'(ob + 16 * t + r));
      exp_pe.push_back(s + 1 + 76 * t + 75);
    end
    exp_done.push_back(s + 1 + 76 * n);
  endtask

  task automatic flush_all();
    exp_feed.delete();
    exp_run.delete();
    exp_ofm.delete();
    exp_pe.delete();
    exp_done.delete();
  endtask

  // mode 0: plain job; 1: extra start pulse during tile-0 WRITE; 2: reset mid-FEED.
  task automatic run_job(input int n, input int ib, input int wb, input int ob, input int mode);
    int s;
    @(posedge clk); #1;
    start     = 1'b1;
    num_tiles = 16'(n);
    ifm_base  = 19'(ib);
    wgt_base  = 9'(wb);
    ofm_base  = 22'(ob);
    s = cyc;
    push_job(s, n, ib, wb, ob);
    @(posedge clk); #1;
    start     = 1'b0;
    num_tiles = 16'd9;
    ifm_base  = 19'($urandom);
    wgt_base  = 9'($urandom);
    ofm_base  = 22'($urandom);
    for (int i = 0; i < 1000; i++) begin
      if (exp_done.size() == 0) break;
      @(posedge clk); #1;
      start = (mode == 1 && cyc == s + 65);
      if (mode == 2 && cyc == s + 20) begin
        rst_n = 1'b0;
        flush_all();
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_read_en", read_en, 0);
        chk("abort_reset_pe", reset_pe, 1);
        chk("abort_done", done, 0);
        return;
      end
    end
    if (exp_done.size() != 0) begin
      miss("done_timeout");
      flush_all();
    end
    repeat (3) @(posedge clk);
    #1;
    chk("leftover_expectations",
        exp_feed.size() + exp_run.size() + exp_ofm.size() + exp_pe.size(), 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_read_en", read_en, 0);
    chk("rst_reset_pe", reset_pe, 1);
    chk("rst_ifm_addr", ifm_addr_a, 0);
    chk("rst_ofm_addr", ofm_addr_b, 0);
    chk("we_a_low", int'(ifm_we_a) + int'(wgt_we_a), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_reset_pe", reset_pe, 0);

    run_job(1, 0, 0, 0, 0);
    run_job(3, 100, 10, 1000, 0);
    run_job(0, 5, 5, 5, 0);
    run_job(1, 0, 0, 0, 1);
    run_job(1, 7, 3, 50, 2);
    run_job(2, 7, 3, 50, 0);
    run_job(1, 0, 0, (1 << 22) - 8, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
